// File: rtl/sevseg_scan_decoder.sv
// Rebuilds the 16-bit hex value shown on a multiplexed, active-low seven-segment
// scan bus. Each digit is captured once its drive has settled, and a full frame is strobed out.
module sevseg_scan_decoder #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  ANODES,
   input  logic [7:0]  CATHODES,
   output logic [15:0] VALUE,
   output logic [3:0]  BLANK,
   output logic [3:0]  DP,
   output logic        VALID,
   output logic        ERR,
   output logic        STALE
);

   localparam int         TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] SMAX = 8'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

   logic [11:0]      in_q, in_d;
   logic [7:0]       stab_q, stab_d;
   logic             dwell_q, dwell_d;
   logic [TW-1:0]    tout_q, tout_d;
   logic [3:0]       seen_q, seen_d;
   logic [3:0][3:0]  sh_nib_q, sh_nib_d;
   logic [3:0]       sh_blank_q, sh_blank_d;
   logic [3:0]       sh_dp_q, sh_dp_d;
   logic             ferr_q, ferr_d;
   logic [15:0]      value_q, value_d;
   logic [3:0]       blank_q, blank_d;
   logic [3:0]       dp_q, dp_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             stale_q, stale_d;

   logic [3:0] an_q;
   logic [7:0] cat_q;
   logic       changed, capture, complete, timeout;
   logic [1:0] dig;
   logic [3:0] dec_nib;
   logic       dec_blank, dec_bad;

   assign an_q  = in_q[11:8];
   assign cat_q = in_q[7:0];

   // Index of the single low anode; only meaningful when capture is asserted.
   always_comb begin
      dig = 2'd0;
      for (int i = 0; i < 4; i++)
         if (!an_q[i]) dig = 2'(i);
   end

   always_comb begin
      dec_nib   = 4'h0;
      dec_blank = 1'b0;
      dec_bad   = 1'b0;
      case (cat_q[6:0])
         7'h40: dec_nib = 4'h0;
         7'h79: dec_nib = 4'h1;
         7'h24: dec_nib = 4'h2;
         7'h30: dec_nib = 4'h3;
         7'h19: dec_nib = 4'h4;
         7'h12: dec_nib = 4'h5;
         7'h02: dec_nib = 4'h6;
         7'h78: dec_nib = 4'h7;
         7'h00: dec_nib = 4'h8;
         7'h10: dec_nib = 4'h9;
         7'h08: dec_nib = 4'hA;
         7'h03: dec_nib = 4'hB;
         7'h46: dec_nib = 4'hC;
         7'h21: dec_nib = 4'hD;
         7'h06: dec_nib = 4'hE;
         7'h0E: dec_nib = 4'hF;
         7'h7F: dec_blank = 1'b1;
         default: dec_bad = 1'b1;
      endcase
   end

   always_comb begin
      in_d     = {ANODES, CATHODES};
      changed  = (in_d != in_q);
      stab_d   = changed ? 8'd0 : ((stab_q == SMAX) ? stab_q : stab_q + 8'd1);
      // Capture lands on the edge where the settle count is reached, using the held value.
      capture  = !changed && (stab_d == SMAX) && $onehot(~an_q) && !dwell_q;
      dwell_d  = changed ? 1'b0 : (dwell_q | capture);
      complete = (seen_q == 4'hF);

      tout_d   = capture ? '0 : ((tout_q == TMAX) ? tout_q : tout_q + TW'(1));
      timeout  = !capture && (tout_d == TMAX);

      seen_d     = seen_q;
      ferr_d     = ferr_q;
      sh_nib_d   = sh_nib_q;
      sh_blank_d = sh_blank_q;
      sh_dp_d    = sh_dp_q;
      if (complete || timeout) begin
         seen_d = 4'h0;
         ferr_d = 1'b0;
      end
      if (capture) begin
         seen_d[dig]     = 1'b1;
         sh_nib_d[dig]   = dec_nib;
         sh_blank_d[dig] = dec_blank;
         sh_dp_d[dig]    = ~cat_q[7];
         if (dec_bad) ferr_d = 1'b1;
      end

      value_d = value_q;
      blank_d = blank_q;
      dp_d    = dp_q;
      err_d   = err_q;
      valid_d = complete;
      stale_d = stale_q;
      if (complete) begin
         value_d = sh_nib_q;
         blank_d = sh_blank_q;
         dp_d    = sh_dp_q;
         err_d   = ferr_q;
         stale_d = 1'b0;
      end else if (timeout) begin
         stale_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         in_q       <= '0;
         stab_q     <= '0;
         dwell_q    <= 1'b0;
         tout_q     <= '0;
         seen_q     <= '0;
         sh_nib_q   <= '0;
         sh_blank_q <= '0;
         sh_dp_q    <= '0;
         ferr_q     <= 1'b0;
         value_q    <= 16'h0000;
         blank_q    <= 4'hF;
         dp_q       <= 4'h0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         stale_q    <= 1'b0;
      end else begin
         in_q       <= in_d;
         stab_q     <= stab_d;
         dwell_q    <= dwell_d;
         tout_q     <= tout_d;
         seen_q     <= seen_d;
         sh_nib_q   <= sh_nib_d;
         sh_blank_q <= sh_blank_d;
         sh_dp_q    <= sh_dp_d;
         ferr_q     <= ferr_d;
         value_q    <= value_d;
         blank_q    <= blank_d;
         dp_q       <= dp_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         stale_q    <= stale_d;
      end
   end

   assign VALUE = value_q;
   assign BLANK = blank_q;
   assign DP    = dp_q;
   assign VALID = valid_q;
   assign ERR   = err_q;
   assign STALE = stale_q;

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Bench for sevseg_scan_decoder: directed frame table, multi-cycle corner sequences,
// and a randomized scan checked against a dwell-level model of the display.
module tb_sevseg_scan_decoder;
   localparam int S = 4;
   localparam int T = 64;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  ANODES;
   logic [7:0]  CATHODES;
   logic [15:0] VALUE;
   logic [3:0]  BLANK, DP;
   logic        VALID, ERR, STALE;

   sevseg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .CLK(CLK), .RST(RST), .ANODES(ANODES), .CATHODES(CATHODES),
      .VALUE(VALUE), .BLANK(BLANK), .DP(DP), .VALID(VALID), .ERR(ERR), .STALE(STALE)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Segment patterns for 0..F as the display encodes them (active low, gfedcba).
   logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct {
      logic [15:0] v;
      logic [3:0]  b;
      logic [3:0]  d;
      logic        e;
   } exp_t;

   exp_t exq[$];
   exp_t mon_e;
   int   vcount = 0;
   logic prev_v = 1'b0;
   bit   rnd_on = 1'b0;
   logic [15:0] snap_val;
   logic [3:0]  snap_blank, snap_dp;
   logic        snap_err, snap_stale;

   always @(negedge CLK) begin
      if (VALID === 1'b1) begin
         vcount++;
         snap_val   = VALUE;
         snap_blank = BLANK;
         snap_dp    = DP;
         snap_err   = ERR;
         snap_stale = STALE;
         chk("valid_back_to_back", prev_v, 1'b0);
         if (rnd_on) begin
            if (exq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rnd_extra_valid: got VALID with value %0h, expected none", VALUE);
            end else begin
               mon_e = exq.pop_front();
               chk("rnd_value", VALUE, mon_e.v);
               chk("rnd_blank", BLANK, mon_e.b);
               chk("rnd_dp", DP, mon_e.d);
               chk("rnd_err", ERR, mon_e.e);
               chk("rnd_stale", STALE, 1'b0);
            end
         end
      end
      prev_v = VALID;
   end

   // Must be entered at a negedge; holds the inputs across n rising edges.
   task automatic drive(input logic [3:0] an, input logic [7:0] cat, input int n);
      ANODES   = an;
      CATHODES = cat;
      repeat (n) @(negedge CLK);
   endtask

   task automatic idle(input int n);
      drive(4'hF, 8'hFF, n);
   endtask

   task automatic dig(input int d, input logic [7:0] cat, input int dw);
      logic [3:0] an;
      an = 4'b0001 << d;
      drive(~an, cat, dw);
      idle(1);
   endtask

   task automatic scan(input logic [3:0][7:0] c, input int dw);
      for (int d = 3; d >= 0; d--) dig(d, c[d], dw);
   endtask

   typedef struct {
      logic [3:0][7:0] c;
      int              dw;
      logic [15:0]     v;
      logic [3:0]      b;
      logic [3:0]      d;
      logic            e;
   } vec_t;

   vec_t tbl [5];

   // Dwell-level model state for the randomized phase.
   logic [3:0][3:0] m_nib;
   logic [3:0]      m_blank, m_dp, m_seen;
   logic            m_err;

   initial begin
      int vb, ign, dw, a, b, r, nd, pushed, vr;
      logic [3:0] an;
      logic [7:0] cat;
      logic [6:0] pat;
      logic       found;

      tbl[0].c = {8'hA4, 8'hB0, 8'h99, 8'h92}; tbl[0].dw = 10;
      tbl[0].v = 16'h2345; tbl[0].b = 4'b0000; tbl[0].d = 4'b0000; tbl[0].e = 1'b0;
      tbl[1].c = {8'hC0, 8'hC0, 8'hFF, 8'h0E}; tbl[1].dw = 10;
      tbl[1].v = 16'h000F; tbl[1].b = 4'b0010; tbl[1].d = 4'b0001; tbl[1].e = 1'b0;
      tbl[2].c = {8'hF9, 8'hD5, 8'hF8, 8'h80}; tbl[2].dw = 8;
      tbl[2].v = 16'h1078; tbl[2].b = 4'b0000; tbl[2].d = 4'b0000; tbl[2].e = 1'b1;
      tbl[3].c = {8'h92, 8'h82, 8'h90, 8'h88}; tbl[3].dw = 7;
      tbl[3].v = 16'h569A; tbl[3].b = 4'b0000; tbl[3].d = 4'b0000; tbl[3].e = 1'b0;
      tbl[4].c = {8'h46, 8'hA1, 8'h86, 8'h83}; tbl[4].dw = 5;
      tbl[4].v = 16'hCDEB; tbl[4].b = 4'b0000; tbl[4].d = 4'b1000; tbl[4].e = 1'b0;

      RST = 1'b1; ANODES = 4'hF; CATHODES = 8'hFF;
      repeat (3) @(negedge CLK);
      chk("rst_value", VALUE, 16'h0000);
      chk("rst_blank", BLANK, 4'hF);
      chk("rst_dp", DP, 4'h0);
      chk("rst_valid", VALID, 1'b0);
      chk("rst_err", ERR, 1'b0);
      chk("rst_stale", STALE, 1'b0);
      RST = 1'b0;
      idle(2);

      for (int i = 0; i < 5; i++) begin
         vb = vcount;
         scan(tbl[i].c, tbl[i].dw);
         idle(3);
         chk($sformatf("tbl%0d_valid_count", i), vcount - vb, 1);
         chk($sformatf("tbl%0d_value", i), snap_val, tbl[i].v);
         chk($sformatf("tbl%0d_blank", i), snap_blank, tbl[i].b);
         chk($sformatf("tbl%0d_dp", i), snap_dp, tbl[i].d);
         chk($sformatf("tbl%0d_err", i), snap_err, tbl[i].e);
      end

      // Dwells of 3 and 4 cycles fall short of the settle window.
      vb = vcount;
      dig(3, 8'hC0, 3); dig(2, 8'hC0, 3); dig(1, 8'hC0, 4); dig(0, 8'hC0, 4);
      idle(2);
      chk("short_dwell_no_valid", vcount - vb, 0);

      // VALID appears one edge after the capture at edge k+S of the last digit.
      dig(3, 8'hC0, 6); dig(2, 8'hF9, 6); dig(1, 8'hA4, 6);
      drive(4'b1110, 8'hB0, S + 1);
      chk("cap_edge_not_yet", VALID, 1'b0);
      drive(4'b1110, 8'hB0, 1);
      chk("cap_edge_valid", VALID, 1'b1);
      idle(2);
      chk("cap_value", VALUE, 16'h0123);

      // Partial frame then silence: stale after T cycles without capture.
      vb = vcount;
      dig(3, 8'hC0, 10);
      drive(4'b1011, 8'hF9, 10);
      idle(T - 6);
      chk("stale_not_yet", STALE, 1'b0);
      idle(1);
      chk("stale_set", STALE, 1'b1);
      chk("stale_value_kept", VALUE, 16'h0123);
      chk("stale_no_valid", vcount - vb, 0);
      dig(1, 8'h99, 10); dig(0, 8'h92, 10);
      idle(2);
      chk("stale_seen_cleared", vcount - vb, 0);
      chk("stale_held", STALE, 1'b1);
      dig(3, 8'hF9, 10); dig(2, 8'hA4, 10);
      idle(2);
      chk("after_stale_valid", vcount - vb, 1);
      chk("after_stale_value", snap_val, 16'h1245);
      chk("after_stale_cleared", snap_stale, 1'b0);

      // Reset mid-frame discards three captured digits.
      dig(3, 8'h82, 10); dig(2, 8'hF8, 10); dig(1, 8'h80, 10);
      RST = 1'b1;
      #1;
      chk("midrst_value", VALUE, 16'h0000);
      chk("midrst_blank", BLANK, 4'hF);
      @(negedge CLK);
      RST = 1'b0;
      vb = vcount;
      dig(0, 8'h90, 10);
      idle(2);
      chk("midrst_no_valid", vcount - vb, 0);
      dig(3, 8'hF9, 10);
      drive(4'b1001, 8'hD5, 10);
      idle(1);
      dig(2, 8'hA4, 10); dig(1, 8'hB0, 10);
      idle(2);
      chk("midrst_fresh_valid", vcount - vb, 1);
      chk("midrst_fresh_value", snap_val, 16'h1239);
      chk("two_low_no_err", snap_err, 1'b0);

      // Randomized scan against a dwell-level model.
      m_seen = 4'h0; m_err = 1'b0; m_nib = '0; m_blank = '0; m_dp = '0;
      ign = 0; pushed = 0; vr = vcount;
      rnd_on = 1'b1;
      for (int i = 0; i < 80; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2 && ign < 2) begin
            a  = int'($urandom_range(0, 3));
            b  = (a + 1 + int'($urandom_range(0, 2))) % 4;
            an = 4'hF;
            an[a] = 1'b0;
            an[b] = 1'b0;
         end else begin
            nd = int'($urandom_range(0, 3));
            an = 4'hF;
            an[nd] = 1'b0;
         end
         r = int'($urandom_range(0, 9));
         if (r < 6)      pat = SEG[$urandom_range(0, 15)];
         else if (r < 7) pat = 7'h7F;
         else            pat = 7'($urandom);
         cat = {1'($urandom_range(0, 1)), pat};
         dw  = (ign >= 2) ? int'($urandom_range(S + 1, 10)) : int'($urandom_range(2, 10));

         if ($countones(~an) == 1 && dw >= S + 1) begin
            ign = 0;
            for (int d = 0; d < 4; d++) if (!an[d]) nd = d;
            found = 1'b0;
            m_nib[nd] = 4'h0;
            for (int k = 0; k < 16; k++)
               if (SEG[k] == pat) begin m_nib[nd] = 4'(k); found = 1'b1; end
            m_blank[nd] = (pat == 7'h7F);
            m_dp[nd]    = ~cat[7];
            if (!found && pat != 7'h7F) m_err = 1'b1;
            m_seen[nd] = 1'b1;
            if (m_seen == 4'hF) begin
               exq.push_back('{v: m_nib, b: m_blank, d: m_dp, e: m_err});
               pushed++;
               m_seen = 4'h0;
               m_err  = 1'b0;
            end
         end else begin
            ign++;
         end
         drive(an, cat, dw);
         idle(1);
      end
      idle(5);
      chk("rnd_queue_drained", exq.size(), 0);
      chk("rnd_valid_count", vcount - vr, pushed);
      rnd_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end
endmodule

// File: doc/sevseg_scan_decoder.md
# sevseg_scan_decoder

Receive-side counterpart of the board's multiplexed seven-segment driver. It watches the active-low `ANODES`/`CATHODES` scan bus and waits for each digit's drive to settle. It decodes each settled cathode pattern back into a hex nibble and, once all four digit positions have been captured, presents the reconstructed 16-bit display value with a one-cycle `VALID` strobe. It is used in wrapper-level benches and on-chip self-check to confirm what the RAT CPU actually put on the display.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive clock edges the scan inputs must hold unchanged before a capture (legal range 2..255).
- `TIMEOUT_CYCLES`, default 65536: cycles without any capture before the frame is marked stale (legal range ≥ 16).
- `CLK` input, 1 bit: system clock; every register updates on the rising edge.
- `RST` input, 1 bit: reset, asynchronous and active-high.
- `ANODES` input, 4 bits: digit selects, active-low; bit n selects digit n, where digit 3 is the most significant.
- `CATHODES` input, 8 bits: segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- `VALUE` output, 16 bits: decoded display value, digit n in bits [4n+3:4n].
- `BLANK` output, 4 bits: bit n is 1 if digit n was blank, meaning all seven segments were off.
- `DP` output, 4 bits: bit n is 1 if the decimal point of digit n was lit.
- `VALID` output, 1 bit: one-cycle pulse when `VALUE`/`BLANK`/`DP`/`ERR` update.
- `ERR` output, 1 bit: the last completed frame contained an undecodable segment pattern.
- `STALE` output, 1 bit: no capture for `TIMEOUT_CYCLES`; held high until the next `VALID`.

## Operation
- Input stage: `ANODES`/`CATHODES` are registered once as `in_q`. A stability counter clears whenever `in_q` differs from its previous value and otherwise counts up, saturating at `SETTLE_CYCLES`.
- Capture condition: the counter reaches `SETTLE_CYCLES`, exactly one anode bit is low, and no capture has yet occurred in this dwell. At most one capture is taken per dwell; the dwell flag clears on any input change.
- Zero anodes low is a blanking gap and is ignored. Two or more anodes low is ignored and sets no error.
- Decode uses `CATHODES[6:0]`:
  - Patterns 0..7: 40 79 24 30 19 12 02 78.
  - Patterns 8..F: 00 10 08 03 46 21 06 0E.
  - Blank: 7F decodes to nibble 0 with blank = 1.
  - Any other pattern decodes to nibble 0, blank = 0, and sets the frame-error flag.
- DP is `~CATHODES[7]`.
- Each capture writes shadow nibble/blank/dp for digit n and sets `seen[n]`. Recapturing an already-seen digit overwrites its shadow entry (latest wins).
- Frame complete means `seen == 4'hF`. On the next edge:
  - shadows are copied to the outputs;
  - `ERR` is set to the frame-error flag;
  - `VALID` is pulsed;
  - `STALE` is cleared;
  - `seen` and the frame-error flag are cleared.
- Timeout counter: cleared on every capture and otherwise increments, saturating. When it reaches `TIMEOUT_CYCLES`:
  - `seen` and the frame-error flag are cleared;
  - `STALE` is set;
  - `VALUE`/`BLANK`/`DP`/`ERR` keep their last values.
- Reset values: `VALUE` 16'h0000, `BLANK` 4'hF, `DP` 4'h0, `VALID` 0, `ERR` 0, `STALE` 0. Also cleared: `seen`, shadows, both counters, the frame-error flag and the dwell flag. Asserting `RST` mid-frame discards the partial frame immediately.

## Timing
- Capture latency: the input change is registered at edge k, and the capture happens at edge k+`SETTLE_CYCLES`. A dwell shorter than `SETTLE_CYCLES`+1 cycles is never captured.
- `VALID` rises on the edge after the capture that completes the frame. It is exactly one cycle wide, and outputs change on that same edge.
- When a completing capture and a timeout fall on the same edge, the capture wins: the timeout counter clears and no stale event occurs.
- `VALID` never occurs on consecutive cycles. The minimum frame period is 4×(`SETTLE_CYCLES`+1) cycles.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then scan digits 3..0 with patterns 24,30,19,12, dwell 10 cycles each → one `VALID`, `VALUE`=16'h2345, `BLANK`=0, `DP`=0, `ERR`=0.
- Dwell of only 3 cycles per digit (`SETTLE_CYCLES`=4) → no captures and no `VALID`. Then hold for 6 cycles → capture at edge k+4.
- Digit 1 given pattern 7F and digit 0 given pattern 0E with CATHODES[7]=0, others 40 → `VALUE`=16'h000F, `BLANK`=4'b0010, `DP`=4'b0001.
- Digit 2 given illegal pattern 55 → `VALID` with `ERR`=1 and nibble 2 = 0. The next clean frame → `ERR`=0.
- Scan digits 3,2 only, then stop (`TIMEOUT_CYCLES`=64) → `STALE`=1 after 64 idle cycles with `VALUE` unchanged. A full frame afterwards → `STALE`=0 and `VALID`.
- Assert `RST` after 3 digits are captured, then scan one digit and release → no `VALID` until a fresh set of 4 digits. Also drive two anodes low → that dwell is ignored.
